// File: rtl/tmr_ctrl_pkg.sv
// Shared types and helpers for the TMR resynchronisation controller.
package tmr_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RESYNC   = 2'd1,
      DEGRADED = 2'd2,
      FATAL    = 2'd3
   } tmr_state_e;

   typedef logic [1:0] replica_id_t;

   localparam replica_id_t REPL_A = 2'd0;
   localparam replica_id_t REPL_B = 2'd1;
   localparam replica_id_t REPL_C = 2'd2;

   // Number of replicas flagging an error.
   function automatic logic [1:0] popcount3(input logic [2:0] e);
      return {1'b0, e[0]} + {1'b0, e[1]} + {1'b0, e[2]};
   endfunction

   // Lowest flagged replica; only meaningful when exactly one bit is set.
   function automatic replica_id_t first_id(input logic [2:0] e);
      if (e[0])      return REPL_A;
      else if (e[1]) return REPL_B;
      else           return REPL_C;
   endfunction

   // One-hot replica mask for a replica index.
   function automatic logic [2:0] id_onehot(input replica_id_t id);
      case (id)
         REPL_A:  return 3'b001;
         REPL_B:  return 3'b010;
         REPL_C:  return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/tmr_fault_counter.sv
// Per-replica saturating fault counter; clear wins over increment.
module tmr_fault_counter #(
   parameter int CntWidth = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                inc_i,
   input  logic                clear_i,
   output logic [CntWidth-1:0] cnt_o
);

   logic [CntWidth-1:0] cnt_q;

   // Count fault events, holding at all-ones instead of wrapping.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (clear_i) begin
         cnt_q <= '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_q <= cnt_q + CntWidth'(1);
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/tmr_resync_ctrl.sv
// Fault-management FSM: resyncs a single bad replica, disables repeat
// offenders or unresponsive replicas, and latches uncorrectable faults.
module tmr_resync_ctrl
   import tmr_ctrl_pkg::*;
#(
   parameter int Threshold     = 3,
   parameter int CntWidth      = 4,
   parameter int TimeoutCycles = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  valid_i,
   input  logic [2:0]            err_i,
   output logic                  resync_req_o,
   output logic [1:0]            resync_id_o,
   input  logic                  resync_ack_i,
   input  logic                  cnt_clear_i,
   output logic [2:0]            replica_disable_o,
   output logic                  fatal_o,
   output logic [1:0]            state_o,
   output logic [3*CntWidth-1:0] fault_cnt_o
);

   localparam int TmoW = $clog2(TimeoutCycles + 1);
   typedef logic [CntWidth-1:0] cnt_t;

   tmr_state_e  state_q, state_d;
   logic        req_q, req_d;
   replica_id_t id_q, id_d;
   logic [2:0]  dis_q, dis_d;
   logic        fatal_q, fatal_d;
   logic [TmoW-1:0] tmo_q, tmo_d;

   logic [2:0]  inc;
   cnt_t        cnt     [3];
   cnt_t        cnt_nxt [3];
   cnt_t        sel_nxt;

   logic [2:0]  err_eff;
   logic [1:0]  nerr;
   replica_id_t err_id;
   logic [2:0]  other_err;

   assign err_eff   = err_i & {3{valid_i}} & ~dis_q;
   assign nerr      = popcount3(err_eff);
   assign err_id    = first_id(err_eff);
   assign other_err = err_eff & ~id_onehot(id_q);

   for (genvar g = 0; g < 3; g++) begin : g_cnt
      tmr_fault_counter #(.CntWidth(CntWidth)) u_cnt (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .inc_i   (inc[g]),
         .clear_i (cnt_clear_i),
         .cnt_o   (cnt[g])
      );
      assign cnt_nxt[g] = (cnt[g] == '1) ? cnt[g] : cnt[g] + cnt_t'(1);
   end

   // Post-increment value of the erring replica, used for the threshold test
   // even when a simultaneous clear zeroes the stored counter.
   assign sel_nxt = (err_id == REPL_A) ? cnt_nxt[0] :
                    (err_id == REPL_B) ? cnt_nxt[1] : cnt_nxt[2];

   // Next-state and registered-output decisions.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      id_d    = id_q;
      dis_d   = dis_q;
      fatal_d = fatal_q;
      tmo_d   = tmo_q;
      inc     = 3'b000;
      case (state_q)
         IDLE: begin
            if (nerr >= 2'd2) begin
               state_d = FATAL;
               fatal_d = 1'b1;
            end else if (nerr == 2'd1) begin
               inc = id_onehot(err_id);
               if (sel_nxt >= cnt_t'(Threshold)) begin
                  dis_d   = dis_q | id_onehot(err_id);
                  state_d = DEGRADED;
               end else begin
                  state_d = RESYNC;
                  req_d   = 1'b1;
                  id_d    = err_id;
                  tmo_d   = '0;
               end
            end
         end
         RESYNC: begin
            // Errors from the replica being resynced are expected and ignored.
            if (other_err != 3'b000) begin
               state_d = FATAL;
               fatal_d = 1'b1;
               req_d   = 1'b0;
            end else if (resync_ack_i) begin
               state_d = IDLE;
               req_d   = 1'b0;
            end else if (tmo_q == TmoW'(TimeoutCycles - 1)) begin
               state_d = DEGRADED;
               dis_d   = dis_q | id_onehot(id_q);
               req_d   = 1'b0;
            end else begin
               tmo_d = tmo_q + TmoW'(1);
            end
         end
         DEGRADED: begin
            if (nerr != 2'd0) begin
               state_d = FATAL;
               fatal_d = 1'b1;
            end
         end
         default: begin
            fatal_d = 1'b1;
            req_d   = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         id_q    <= REPL_A;
         dis_q   <= 3'b000;
         fatal_q <= 1'b0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         id_q    <= id_d;
         dis_q   <= dis_d;
         fatal_q <= fatal_d;
         tmo_q   <= tmo_d;
      end
   end

   assign resync_req_o      = req_q;
   assign resync_id_o       = id_q;
   assign replica_disable_o = dis_q;
   assign fatal_o           = fatal_q;
   assign state_o           = state_q;
   assign fault_cnt_o       = {cnt[2], cnt[1], cnt[0]};

endmodule

// File: tb/tb_tmr_resync_ctrl.sv
// Bench for tmr_resync_ctrl: directed scenarios plus random traffic, all
// compared every cycle against an abstract model of the controller rules.
module tb_tmr_resync_ctrl;

   localparam int THR  = 3;
   localparam int CW   = 4;
   localparam int TMO  = 16;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n, valid, ack, clr;
   logic [2:0]    err;
   logic          req, fatal;
   logic [1:0]    id, state;
   logic [2:0]    dis;
   logic [3*CW-1:0] cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: mode 0 normal, 1 resync pending, 2 running degraded, 3 dead.
   int m_mode = 0;
   int m_id   = 0;
   int m_wait = 0;
   int m_dis  = 0;
   int m_cnt [3] = '{0, 0, 0};

   tmr_resync_ctrl #(.Threshold(THR), .CntWidth(CW), .TimeoutCycles(TMO)) dut (
      .clk_i             (clk),
      .rst_ni            (rst_n),
      .valid_i           (valid),
      .err_i             (err),
      .resync_req_o      (req),
      .resync_id_o       (id),
      .resync_ack_i      (ack),
      .cnt_clear_i       (clr),
      .replica_disable_o (dis),
      .fatal_o           (fatal),
      .state_o           (state),
      .fault_cnt_o       (cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_update();
      int eff, n, r, other;
      if (!rst_n) begin
         m_mode = 0; m_id = 0; m_wait = 0; m_dis = 0;
         m_cnt = '{0, 0, 0};
         return;
      end
      eff = valid ? (int'(err) & ~m_dis & 7) : 0;
      n   = $countones(eff);
      case (m_mode)
         0: begin
            if (n >= 2) m_mode = 3;
            else if (n == 1) begin
               r = eff[0] ? 0 : (eff[1] ? 1 : 2);
               m_cnt[r] = (m_cnt[r] < CMAX) ? m_cnt[r] + 1 : CMAX;
               if (m_cnt[r] >= THR) begin
                  m_dis |= (1 << r);
                  m_mode = 2;
               end else begin
                  m_mode = 1; m_id = r; m_wait = 0;
               end
            end
         end
         1: begin
            other = eff & ~(1 << m_id);
            if (other != 0) m_mode = 3;
            else if (ack) m_mode = 0;
            else begin
               m_wait++;
               if (m_wait == TMO) begin
                  m_dis |= (1 << m_id);
                  m_mode = 2;
               end
            end
         end
         2: if (n >= 1) m_mode = 3;
         default: ;
      endcase
      if (clr) m_cnt = '{0, 0, 0};
   endtask

   task automatic compare();
      chk("state", int'(state), m_mode);
      chk("req", int'(req), int'(m_mode == 1));
      if (m_mode == 1) chk("id", int'(id), m_id);
      chk("disable", int'(dis), m_dis);
      chk("fatal", int'(fatal), int'(m_mode == 3));
      chk("cnt", int'(cnt), m_cnt[0] | (m_cnt[1] << CW) | (m_cnt[2] << (2 * CW)));
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      compare();
   endtask

   task automatic idle_in();
      rst_n = 1'b1; valid = 1'b1; err = 3'b000; ack = 1'b0; clr = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; err = 3'b000; ack = 1'b0; clr = 1'b0;
      step(); step();
      idle_in();
   endtask

   // One acked B event: error, two masked B errors, then the ack.
   task automatic b_event_acked();
      err = 3'b010; step();
      err = 3'b010; step();
      err = 3'b010; step();
      err = 3'b000; ack = 1'b1; step();
      ack = 1'b0;
   endtask

   initial begin
      idle_in();
      rst_n = 1'b0;
      do_reset();
      chk("reset_state", int'(state), 0);
      chk("reset_outs", int'({req, id, dis, fatal}), 0);
      chk("reset_cnt", int'(cnt), 0);
      for (int i = 0; i < 10; i++) step();
      chk("quiet_state", int'(state), 0);

      // Single B fault, resync acked; masked B errors do not count.
      err = 3'b010; step();
      chk("b1_req", int'(req), 1);
      chk("b1_id", int'(id), 1);
      chk("b1_cnt", int'(cnt), 12'h010);
      err = 3'b010; step();
      err = 3'b010; step();
      err = 3'b000; ack = 1'b1; step();
      ack = 1'b0;
      chk("b1_ack_req", int'(req), 0);
      chk("b1_ack_state", int'(state), 0);
      chk("b1_masked_cnt", int'(cnt), 12'h010);
      b_event_acked();
      chk("b2_cnt", int'(cnt), 12'h020);
      err = 3'b010; step();
      err = 3'b000;
      chk("b3_dis", int'(dis), 3'b010);
      chk("b3_state", int'(state), 2);
      chk("b3_req", int'(req), 0);
      step();
      err = 3'b001; step();
      err = 3'b000;
      chk("deg_fatal", int'(fatal), 1);
      chk("deg_state", int'(state), 3);

      // Resync of C without ack times out after TMO request cycles.
      do_reset();
      err = 3'b100; step();
      err = 3'b000;
      for (int i = 0; i < TMO - 1; i++) step();
      chk("tmo_still_req", int'(req), 1);
      step();
      chk("tmo_dis", int'(dis), 3'b100);
      chk("tmo_req", int'(req), 0);
      chk("tmo_state", int'(state), 2);

      // Double fault in IDLE.
      do_reset();
      err = 3'b011; step();
      err = 3'b000;
      chk("dbl_state", int'(state), 3);

      // Other-replica error beats a simultaneous ack.
      do_reset();
      err = 3'b001; step();
      err = 3'b010; ack = 1'b1; step();
      err = 3'b000; ack = 1'b0;
      chk("ackfatal_state", int'(state), 3);
      chk("ackfatal_req", int'(req), 0);

      // Reset in the middle of a resync.
      do_reset();
      err = 3'b001; step();
      err = 3'b000;
      rst_n = 1'b0; step();
      rst_n = 1'b1;
      chk("midrst_all", int'({req, dis, fatal, state}), 0);
      chk("midrst_cnt", int'(cnt), 0);

      // Clear together with an error event.
      err = 3'b010; clr = 1'b1; step();
      err = 3'b000; clr = 1'b0;
      chk("clr_cnt", int'(cnt), 0);
      chk("clr_req", int'(req), 1);
      chk("clr_id", int'(id), 1);
      ack = 1'b1; step();
      ack = 1'b0;

      // Random traffic.
      for (int i = 0; i < 4000; i++) begin
         int p;
         p = int'($urandom_range(0, 99));
         if (p < 12)      err = 3'b001 << $urandom_range(0, 2);
         else if (p < 14) err = 3'($urandom_range(0, 7));
         else             err = 3'b000;
         valid = ($urandom_range(0, 7) != 0);
         ack   = ($urandom_range(0, 5) == 0);
         clr   = ($urandom_range(0, 59) == 0);
         rst_n = !(((m_mode >= 2) && ($urandom_range(0, 14) == 0)) ||
                   ($urandom_range(0, 299) == 0));
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tmr_resync_ctrl.md
Name: tmr_resync_ctrl

Overview:
- Fault-management controller for a bank of TMR_voter_detect voters protecting one triplicated unit.
- Consumes the per-replica error flags (err_a/b/c, OR-reduced across the bank) and sequences resynchronisation of a mismatching replica through a req/ack handshake.
- Tracks per-replica fault history and permanently disables a replica that exceeds a fault threshold or fails to resync.
- Escalates to a sticky fatal state when two replicas disagree, which is uncorrectable.

Parameters:
- Threshold, 3: number of counted fault events on one replica that disables it (1..2^CntWidth-1).
- CntWidth, 4: width of each per-replica saturating fault counter.
- TimeoutCycles, 16: maximum cycles resync_req_o may wait for resync_ack_i (>=1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- valid_i  in  1  err_i qualifier; err_i is ignored when low
- err_i  in  3  per-replica mismatch flags from voter bank; bit0=A, bit1=B, bit2=C
- resync_req_o  out  1  request resync of replica resync_id_o
- resync_id_o  out  2  replica under resync (0..2); stable while resync_req_o is high
- resync_ack_i  in  1  resync complete, single-cycle pulse
- cnt_clear_i  in  1  clear all fault counters; does not affect disable or fatal state
- replica_disable_o  out  3  sticky mask of permanently failed replicas
- fatal_o  out  1  sticky uncorrectable fault
- state_o  out  2  current FSM state, for status CSR
- fault_cnt_o  out  3*CntWidth  per-replica counters, replica A in the LSBs

Behaviour:
- Reset (synchronous, rst_ni=0 at a posedge): state IDLE; all outputs 0; counters 0; timeout counter 0. Reset asserted mid-resync drops resync_req_o on the next edge with no ack required.
- err_eff = err_i & {3{valid_i}} & ~replica_disable_o. nerr = popcount(err_eff).
- States: IDLE=0, RESYNC=1, DEGRADED=2, FATAL=3. All outputs are registered; response appears 1 cycle after the sampled edge.
- IDLE:
  - nerr>=2 -> FATAL.
  - nerr==1 on replica r: cnt[r] saturating-increments.
    - If the new value >= Threshold: set replica_disable_o[r] -> DEGRADED.
    - Otherwise -> RESYNC with resync_id_o=r, resync_req_o=1, timeout counter cleared.
- RESYNC:
  - Errors on resync_id_o are masked and not counted, since the replica is known bad.
  - Any error on another replica -> FATAL; resync_req_o drops.
  - resync_ack_i=1 -> resync_req_o=0 -> IDLE.
  - Timeout counter reaches TimeoutCycles without ack -> disable resync_id_o, resync_req_o=0 -> DEGRADED.
  - Ack and another-replica error in the same cycle: FATAL wins.
  - Ack and a masked error in the same cycle: IDLE.
- DEGRADED (one replica disabled; the unit runs as DMR): nerr>=1 on a remaining replica -> FATAL. No resync is issued. Stays until reset.
- FATAL: absorbing; fatal_o=1; resync_req_o=0; only reset exits.
- cnt_clear_i zeroes all counters in any state. It takes priority over an increment in the same cycle, so the counter ends at 0 but the transition for that event still occurs.
- Counters saturate at 2^CntWidth-1 and never wrap.
- resync_ack_i while not in RESYNC is ignored.
- replica_disable_o holds at most one set bit. A second failure goes to FATAL rather than setting a second disable bit.

Decomposition:
- Package tmr_ctrl_pkg holds:
  - tmr_state_e enum: IDLE, RESYNC, DEGRADED, FATAL; 2 bits.
  - replica_id_t: logic [1:0].
  - Constants for replica indices A=0, B=1, C=2.
- Sub-module tmr_fault_counter: saturating CntWidth counter with inc and clear inputs, clear priority, instantiated 3x.
- FSM and timeout counter live in the top module.

Test Plan:
- Reset then valid_i=1, err_i=3'b000 for 10 cycles -> state_o=0, all outputs 0.
- err_i=3'b010 for one cycle -> next cycle resync_req_o=1, resync_id_o=1, fault_cnt B=1. Ack pulse 3 cycles later -> req drops the next cycle, state IDLE. Errors on B during the wait do not increment the counter.
- Three separate B error events, each acked (Threshold=3) -> the third event gives replica_disable_o=3'b010, state DEGRADED, no request. A following err_i=3'b001 -> fatal_o=1, state FATAL.
- err_i=3'b100, ack withheld -> after 16 cycles of req, replica_disable_o=3'b100, req=0, state DEGRADED.
- err_i=3'b011 in IDLE -> FATAL next cycle. Separately: during a resync of A, err_i=3'b010 together with an ack -> FATAL.
- Reset pulled low during RESYNC -> all outputs 0 and IDLE on the next edge. Also: cnt_clear_i together with an error event -> counter reads 0 while the resync is still issued.
